// File: rtl/aidan_mcnay_sipo_ctrl_pkg.sv
// Shared constants for the serial frame loader and the prime detector top.
// Both sides use this state encoding and default frame width, so they always agree.
package aidan_mcnay_sipo_ctrl_pkg;

   localparam int NBITS_DEFAULT = 16;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t SHIFT  = 2'd1;
   localparam state_t PARITY = 2'd2;
   localparam state_t HOLD   = 2'd3;

endpackage

// File: rtl/aidan_mcnay_sipo.sv
// Serial-in parallel-out shift register, MSB-first: the newest bit enters at [0].
// One-cycle update when en=1; reset is active-high and asynchronous.
module aidan_mcnay_sipo #(
   parameter int nbits = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             data_in,
   output logic [nbits-1:0] data_out
);

   logic [nbits-1:0] data_q;
   logic [nbits-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (en) begin
         data_d = {data_q[nbits-2:0], data_in};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_out = data_q;

endmodule

// File: rtl/aidan_mcnay_sipo_ctrl.sv
// Frame loader: bits -> SIPO -> word on out_valid one cycle after the last bit.
// Backpressure: in_ready drops while a word is held; AIDAN_MCNAY_SIPO_CTRL_PARITY_EN adds a trailing parity bit.
module aidan_mcnay_sipo_ctrl
   import aidan_mcnay_sipo_ctrl_pkg::*;
#(
   parameter int nbits = NBITS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_start,
   input  logic             in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [nbits-1:0] out_data,
   output logic             out_parity_err
);

   localparam int CW = $clog2(nbits + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(nbits - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             accept;
   logic             sipo_en;
   logic [nbits-1:0] sipo_q;

`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
   logic             parity_err_q;
   logic             parity_err_d;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Next-state and counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept && in_start) begin
               state_d = SHIFT;
               cnt_d   = CNT_ONE;
            end
         end
         SHIFT: begin
            if (accept) begin
               // A start marker mid-frame restarts; the old bits age out of the SIPO.
               if (in_start) begin
                  cnt_d = CNT_ONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (cnt_q == CNT_LAST) begin
`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = HOLD;
`endif
                  end
               end
            end
         end
`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
         PARITY: begin
            if (accept) begin
               parity_err_d = (^sipo_q) ^ in_data;
               state_d      = HOLD;
            end
         end
`endif
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q != HOLD);
      out_valid = (state_q == HOLD);
      accept    = in_valid & in_ready;
      sipo_en   = accept & (((state_q == IDLE) & in_start) | (state_q == SHIFT));
   end

   aidan_mcnay_sipo #(
      .nbits (nbits)
   ) u_sipo (
      .clk      (clk),
      .reset    (~reset),
      .en       (sipo_en),
      .data_in  (in_data),
      .data_out (sipo_q)
   );

   assign out_data = sipo_q;

`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
   assign out_parity_err = parity_err_q & out_valid;
`else
   assign out_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_aidan_mcnay_sipo_ctrl.sv
// Directed bench for the serial frame loader; tracks AIDAN_MCNAY_SIPO_CTRL_PARITY_EN.
module tb_aidan_mcnay_sipo_ctrl;

   localparam int NB = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_start;
   logic          in_data;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [NB-1:0] out_data;
   logic          out_parity_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   aidan_mcnay_sipo_ctrl #(
      .nbits (NB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_start       (in_start),
      .in_data        (in_data),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_parity_err (out_parity_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic d, input logic s);
      in_valid = 1'b1;
      in_data  = d;
      in_start = s;
      tick();
      in_valid = 1'b0;
      in_start = 1'b0;
      in_data  = 1'b0;
   endtask

   // First n bits of w, MSB first, start marker on the first bit.
   task automatic send_bits(input logic [NB-1:0] w, input int n, input bit gaps);
      for (int i = NB - 1; i >= NB - n; i--) begin
         send_bit(w[i], (i == NB - 1));
         if (gaps) repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic send_frame(input logic [NB-1:0] w, input bit gaps);
      send_bits(w, NB, gaps);
`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
      send_bit(^w, 1'b1);
`endif
   endtask

   task automatic release_word();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      bit seen;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_start  = 1'b0;
      in_data   = 1'b0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_in_ready",  in_ready,       1);
      chk("rst_out_valid", out_valid,      0);
      chk("rst_out_data",  out_data,       0);
      chk("rst_par_err",   out_parity_err, 0);
      reset = 1'b1;
      tick();

      // Nominal back-to-back frame
      send_bits(16'hFFF1, 15, 0);
      chk("nom_valid_early", out_valid, 0);
      send_bit(1'b1, 1'b0);
`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
      chk("nom_parity_state_rdy", in_ready, 1);
      send_bit(1'b1, 1'b0);
`endif
      chk("nom_valid",    out_valid,      1);
      chk("nom_data",     out_data,       16'hFFF1);
      chk("nom_in_ready", in_ready,       0);
      chk("nom_par_err",  out_parity_err, 0);
      tick();
      chk("nom_held_rdy", in_ready,       0);
      release_word();
      chk("nom_idle_valid", out_valid, 0);
      chk("nom_idle_rdy",   in_ready,  1);

      // Gaps and backpressure; bits offered while held must be ignored
      send_frame(16'h0007, 1);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_start = 1'b1;
         in_data  = c[0];
         chk("bp_valid", out_valid, 1);
         chk("bp_data",  out_data,  16'h0007);
         tick();
      end
      in_valid = 1'b0;
      in_start = 1'b0;
      release_word();
      chk("bp_idle_valid", out_valid, 0);
      chk("bp_idle_rdy",   in_ready,  1);
      chk("bp_data_kept",  out_data,  16'h0007);

      // Restart after 9 bits of an aborted frame
      send_bits(16'hAAAA, 9, 0);
      chk("rs_no_valid_9", out_valid, 0);
      send_bits(16'h1234, 15, 0);
      chk("rs_no_valid_15", out_valid, 0);
      send_bit(1'b0, 1'b0);
`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
      send_bit(1'b1, 1'b0);
`endif
      chk("rs_valid", out_valid, 1);
      chk("rs_data",  out_data,  16'h1234);
      release_word();
      chk("rs_single", out_valid, 0);

      // Stray bits in IDLE
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         in_valid = 1'b1;
         in_start = 1'b0;
         in_data  = c[0];
         tick();
         seen |= out_valid;
      end
      in_valid = 1'b0;
      chk("stray_no_valid", seen,     0);
      chk("stray_sipo",     out_data, 16'h1234);
      chk("stray_rdy",      in_ready, 1);

      // Asynchronous reset mid-frame
      send_bits(16'hFFFF, 10, 0);
      #2 reset = 1'b0;
      #1;
      chk("rmf_valid",   out_valid, 0);
      chk("rmf_data",    out_data,  0);
      chk("rmf_rdy",     in_ready,  1);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      tick();
      // Without a start marker nothing is framed after reset
      seen = 1'b0;
      for (int c = 0; c < NB + 1; c++) begin
         send_bit(1'b1, 1'b0);
         seen |= out_valid;
      end
      chk("rmf_need_start", seen,     0);
      chk("rmf_sipo_still", out_data, 0);
      send_frame(16'h0101, 0);
      chk("rmf_next_valid", out_valid, 1);
      chk("rmf_next_data",  out_data,  16'h0101);

      // Asynchronous reset mid-hold
      #2 reset = 1'b0;
      #1;
      chk("rmh_valid", out_valid, 0);
      chk("rmh_data",  out_data,  0);
      chk("rmh_rdy",   in_ready,  1);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      tick();

`ifdef AIDAN_MCNAY_SIPO_CTRL_PARITY_EN
      // Even parity: 0x0003 has even weight
      send_bits(16'h0003, 16, 0);
      chk("par_wait_valid", out_valid, 0);
      chk("par_wait_rdy",   in_ready,  1);
      send_bit(1'b0, 1'b1);
      chk("par0_valid", out_valid,      1);
      chk("par0_data",  out_data,       16'h0003);
      chk("par0_err",   out_parity_err, 0);
      release_word();
      send_bits(16'h0003, 16, 0);
      send_bit(1'b1, 1'b0);
      chk("par1_valid", out_valid,      1);
      chk("par1_data",  out_data,       16'h0003);
      chk("par1_err",   out_parity_err, 1);
      tick();
      chk("par1_err_held", out_parity_err, 1);
      release_word();
`else
      send_frame(16'hFFFE, 0);
      chk("nopar_data", out_data,       16'hFFFE);
      chk("nopar_err",  out_parity_err, 0);
      release_word();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
